// File: rtl/arb_grant_hold.sv
// Registered grant-hold stage behind the daisy-chain arbiter: latches a legal
// one-hot grant and holds bus ownership until release or hold-budget expiry.
module arb_grant_hold #(
  parameter  int unsigned N       = 8,
  parameter  int unsigned MAXHOLD = 16,
  localparam int unsigned IW      = $clog2(N),
  localparam int unsigned CW      = $clog2(MAXHOLD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:N-1]  req,
  input  logic [0:N-1]  arb_gnt,
  output logic [0:N-1]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic [CW-1:0] hold_cnt,
  output logic          expired,
  output logic          arb_err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAXHOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t        state, state_d;
  logic [0:N-1]  gnt_d;
  logic [IW-1:0] idx_d;
  logic [CW-1:0] cnt_d;
  logic          expired_d;
  logic          arb_err_d;

  logic [IW-1:0] arb_idx;
  logic          arb_legal;
  logic          owner_req;
  logic          others_req;

  // Position of the arbiter's grant bit; only meaningful when arb_gnt is one-hot.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_gnt[i]) arb_idx = IW'(i);
    end
  end

  assign arb_legal  = $onehot(arb_gnt) && ((arb_gnt & req) == arb_gnt);
  assign owner_req  = |(req & gnt);
  assign others_req = |(req & ~gnt);
  assign gnt_valid  = |gnt;

  // State register plus the registered outputs, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
      expired  <= 1'b0;
      arb_err  <= 1'b0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      gnt_idx  <= idx_d;
      hold_cnt <= cnt_d;
      expired  <= expired_d;
      arb_err  <= arb_err_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    idx_d     = gnt_idx;
    cnt_d     = hold_cnt;
    expired_d = 1'b0;
    arb_err_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (arb_gnt != '0) begin
          if (arb_legal) begin
            gnt_d   = arb_gnt;
            idx_d   = arb_idx;
            cnt_d   = '0;
            state_d = S_GRANT;
          end else begin
            arb_err_d = 1'b1;
          end
        end
      end

      S_GRANT: begin
        // Owner release takes precedence over budget expiry on the same edge.
        if (!owner_req) begin
          gnt_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if ((hold_cnt == CNT_MAX) && others_req) begin
          gnt_d     = '0;
          idx_d     = '0;
          cnt_d     = '0;
          expired_d = 1'b1;
          state_d   = S_RELEASE;
        end else if (hold_cnt != CNT_MAX) begin
          cnt_d = hold_cnt + CW'(1);
        end
      end

      S_RELEASE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_arb_grant_hold.sv
// Directed self-checking bench for arb_grant_hold (N=8, MAXHOLD=16).
module tb_arb_grant_hold;

  logic       clk;
  logic       reset;
  logic [0:7] req;
  logic [0:7] arb_gnt;
  logic [0:7] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [3:0] hold_cnt;
  logic       expired;
  logic       arb_err;

  int total = 0;
  int bad   = 0;

  arb_grant_hold #(.N(8), .MAXHOLD(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .arb_gnt  (arb_gnt),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx),
    .hold_cnt (hold_cnt),
    .expired  (expired),
    .arb_err  (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drop all requests and let the owner release back to IDLE.
  task automatic go_idle();
    req     = '0;
    arb_gnt = '0;
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    total++; if (gnt !== 8'b0000_0000) begin bad++; $display("FAIL reset_gnt got=%b want=%b", gnt, 8'b0); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", gnt_valid); end
    total++; if (gnt_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", gnt_idx); end
    total++; if (hold_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", hold_cnt); end
    total++; if (expired !== 1'b0 || arb_err !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", expired, arb_err); end
    reset = 1'b0;
    step();
    total++; if (gnt !== 8'b0010_0000) begin bad++; $display("FAIL first_gnt got=%b want=%b", gnt, 8'b0010_0000); end
    total++; if (gnt_idx !== 3'd2) begin bad++; $display("FAIL first_idx got=%0d want=2", gnt_idx); end
    total++; if (gnt_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", gnt_valid); end
    total++; if (hold_cnt !== 4'd0) begin bad++; $display("FAIL first_cnt got=%0d want=0", hold_cnt); end
  endtask

  task automatic test_release();
    req     = 8'b0010_0100;
    arb_gnt = 8'b0010_0000;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if (hold_cnt !== 4'(k) || gnt !== 8'b0010_0000) begin bad++; $display("FAIL hold2_k%0d got cnt=%0d gnt=%b want cnt=%0d gnt=%b", k, hold_cnt, gnt, k, 8'b0010_0000); end
    end
    req     = 8'b0000_0100;
    arb_gnt = 8'b0000_0100;
    step();
    total++; if (gnt !== 8'b0 || gnt_valid !== 1'b0) begin bad++; $display("FAIL rel_gnt got=%b valid=%b want=0", gnt, gnt_valid); end
    total++; if (expired !== 1'b0) begin bad++; $display("FAIL rel_expired got=%b want=0", expired); end
    step();
    total++; if (gnt !== 8'b0) begin bad++; $display("FAIL rel_dead got=%b want=0", gnt); end
    step();
    total++; if (gnt !== 8'b0000_0100 || gnt_idx !== 3'd5) begin bad++; $display("FAIL next_owner got gnt=%b idx=%0d want gnt=%b idx=5", gnt, gnt_idx, 8'b0000_0100); end
    go_idle();
  endtask

  task automatic test_expire();
    req     = 8'b1000_0001;
    arb_gnt = 8'b1000_0000;
    step();
    total++; if (gnt !== 8'b1000_0000 || gnt_idx !== 3'd0 || hold_cnt !== 4'd0) begin bad++; $display("FAIL exp_grant got gnt=%b idx=%0d cnt=%0d", gnt, gnt_idx, hold_cnt); end
    for (int k = 1; k <= 15; k++) begin
      step();
      total++; if (hold_cnt !== 4'(k) || gnt !== 8'b1000_0000 || expired !== 1'b0) begin bad++; $display("FAIL exp_hold_k%0d got cnt=%0d gnt=%b exp=%b", k, hold_cnt, gnt, expired); end
    end
    step();
    total++; if (expired !== 1'b1 || gnt !== 8'b0 || hold_cnt !== 4'd0) begin bad++; $display("FAIL exp_pulse got exp=%b gnt=%b cnt=%0d want 1/0/0", expired, gnt, hold_cnt); end
    arb_gnt = 8'b0000_0001;
    step();
    total++; if (expired !== 1'b0 || gnt !== 8'b0) begin bad++; $display("FAIL exp_after got exp=%b gnt=%b want 0/0", expired, gnt); end
    step();
    total++; if (gnt !== 8'b0000_0001 || gnt_idx !== 3'd7 || hold_cnt !== 4'd0) begin bad++; $display("FAIL exp_next got gnt=%b idx=%0d cnt=%0d want %b/7/0", gnt, gnt_idx, hold_cnt, 8'b0000_0001); end
  endtask

  // Continues with owner 7 in GRANT and requester 0 still pending.
  task automatic test_drop_at_limit();
    for (int k = 1; k <= 15; k++) begin
      step();
      total++; if (hold_cnt !== 4'(k) || gnt !== 8'b0000_0001) begin bad++; $display("FAIL lim_hold_k%0d got cnt=%0d gnt=%b", k, hold_cnt, gnt); end
    end
    req = 8'b1000_0000;
    step();
    total++; if (gnt !== 8'b0 || expired !== 1'b0) begin bad++; $display("FAIL lim_release got gnt=%b exp=%b want 0/0", gnt, expired); end
    go_idle();
  endtask

  task automatic test_solo();
    req     = 8'b0000_0010;
    arb_gnt = 8'b0000_0010;
    step();
    total++; if (gnt !== 8'b0000_0010 || gnt_idx !== 3'd6) begin bad++; $display("FAIL solo_grant got gnt=%b idx=%0d want %b/6", gnt, gnt_idx, 8'b0000_0010); end
    for (int k = 1; k <= 20; k++) begin
      step();
      total++; if (hold_cnt !== ((k > 15) ? 4'd15 : 4'(k)) || gnt !== 8'b0000_0010 || expired !== 1'b0) begin bad++; $display("FAIL solo_k%0d got cnt=%0d gnt=%b exp=%b", k, hold_cnt, gnt, expired); end
    end
    req = 8'b0100_0010;
    step();
    total++; if (expired !== 1'b1 || gnt !== 8'b0) begin bad++; $display("FAIL solo_preempt got exp=%b gnt=%b want 1/0", expired, gnt); end
    go_idle();
  endtask

  task automatic test_arb_err();
    req     = 8'b1100_0000;
    arb_gnt = 8'b1100_0000;
    step();
    total++; if (arb_err !== 1'b1 || gnt !== 8'b0 || gnt_valid !== 1'b0) begin bad++; $display("FAIL err_multi got err=%b gnt=%b valid=%b want 1/0/0", arb_err, gnt, gnt_valid); end
    req     = '0;
    arb_gnt = '0;
    step();
    total++; if (arb_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", arb_err); end
    arb_gnt = 8'b0000_0001;
    step();
    total++; if (arb_err !== 1'b1 || gnt !== 8'b0) begin bad++; $display("FAIL err_noreq got err=%b gnt=%b want 1/0", arb_err, gnt); end
    arb_gnt = '0;
    step();
    total++; if (arb_err !== 1'b0 || gnt !== 8'b0) begin bad++; $display("FAIL err_end got err=%b gnt=%b want 0/0", arb_err, gnt); end
  endtask

  task automatic test_async_reset();
    req     = 8'b0001_0000;
    arb_gnt = 8'b0001_0000;
    step();
    total++; if (gnt !== 8'b0001_0000 || gnt_idx !== 3'd3) begin bad++; $display("FAIL ar_grant got gnt=%b idx=%0d want %b/3", gnt, gnt_idx, 8'b0001_0000); end
    step();
    step();
    total++; if (hold_cnt !== 4'd2) begin bad++; $display("FAIL ar_cnt got=%0d want=2", hold_cnt); end
    #3 reset = 1'b1;
    #1;
    total++; if (gnt !== 8'b0 || gnt_valid !== 1'b0) begin bad++; $display("FAIL ar_gnt got gnt=%b valid=%b want 0/0", gnt, gnt_valid); end
    total++; if (gnt_idx !== 3'd0 || hold_cnt !== 4'd0) begin bad++; $display("FAIL ar_idx_cnt got idx=%0d cnt=%0d want 0/0", gnt_idx, hold_cnt); end
    req     = '0;
    arb_gnt = '0;
    step();
    reset = 1'b0;
    step();
    total++; if (gnt !== 8'b0) begin bad++; $display("FAIL ar_idle got=%b want=0", gnt); end
    req     = 8'b0100_0000;
    arb_gnt = 8'b0100_0000;
    step();
    total++; if (gnt !== 8'b0100_0000 || gnt_idx !== 3'd1) begin bad++; $display("FAIL ar_regrant got gnt=%b idx=%0d want %b/1", gnt, gnt_idx, 8'b0100_0000); end
    go_idle();
  endtask

  initial begin
    reset   = 1'b1;
    req     = 8'b0010_0000;
    arb_gnt = 8'b0010_0000;
    step();
    step();
    test_reset();
    test_release();
    test_expire();
    test_drop_at_limit();
    test_solo();
    test_arb_err();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
